// File: rtl/trap_unit.sv
// ---------------------------------------------------------------------------
// trap_unit
//   Machine-mode trap/return sequencer. Once per visit of the core FSM to its
//   CONTROL stage it either takes a trap (fault, external or software
//   interrupt), executes an mret, or does nothing. Trap entry updates
//   mepc/mcause/mtval/mstatus and emits a one-cycle redirect to mtvec; mret
//   restores mstatus.MIE and redirects to mepc. Also holds the trap CSRs and
//   exports the interrupt-enable gates used by the core's interrupt sources.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   control_stage        CONTROL stage active (>=2 cycles per visit)
//   control_op           00 trap, 01 ext_int, 10 sw_int, 11 normal
//   fault_num            fault code for control_op 00
//   mret                 instruction is mret (only with control_op 11)
//   pc                   PC of the faulting/interrupted instruction
//   fault_addr           offending address for memory faults
//   instr                raw instruction word (mtval on illegal instruction)
//   csr_addr/wr_en/wdata CSR access port (writes apply at the clock edge)
//   csr_rdata            combinational CSR read, 0 for unmapped addresses
//   redirect_valid/pc    one-cycle fetch redirect; pc holds between pulses
//   ext_int_en           mstatus.MIE & mie.MEIE
//   sw_int_en            mstatus.MIE & mie.MSIE
// ---------------------------------------------------------------------------
module trap_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            control_stage,
  input  logic [1:0]      control_op,
  input  logic [2:0]      fault_num,
  input  logic            mret,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] fault_addr,
  input  logic [XLEN-1:0] instr,
  input  logic [11:0]     csr_addr,
  input  logic            csr_wr_en,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            ext_int_en,
  output logic            sw_int_en
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [1:0] OP_TRAP   = 2'b00;
  localparam logic [1:0] OP_EXT    = 2'b01;
  localparam logic [1:0] OP_SW     = 2'b10;
  localparam logic [1:0] OP_NORMAL = 2'b11;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] CAUSE_EXT  = {1'b1, {(XLEN-5){1'b0}}, 4'd11};
  localparam logic [XLEN-1:0] CAUSE_SW   = {1'b1, {(XLEN-5){1'b0}}, 4'd3};

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    COMMIT,
    DONE
  } state_t;

  state_t          state;
  logic            control_stage_q;

  logic [1:0]      op_q;
  logic [2:0]      fault_q;
  logic            mret_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] instr_q;

  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic            mie_meie;
  logic            mie_msie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mtval;

  logic            commit_trap;
  logic            commit_mret;
  logic [2:0]      fault_code;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_val;

  // Visit sequencer. control_stage_q resets high so that a CONTROL stage
  // already in progress when reset is released is not mistaken for a new
  // visit. The redirect is decided on the CAPTURE->COMMIT edge from the same
  // values being latched, so the pulse lands in the COMMIT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      control_stage_q <= 1'b1;
      op_q            <= OP_NORMAL;
      fault_q         <= 3'b000;
      mret_q          <= 1'b0;
      pc_q            <= '0;
      addr_q          <= '0;
      instr_q         <= '0;
      redirect_valid  <= 1'b0;
      redirect_pc     <= '0;
    end else begin
      control_stage_q <= control_stage;
      redirect_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (control_stage && !control_stage_q) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          state   <= COMMIT;
          op_q    <= control_op;
          fault_q <= fault_num;
          mret_q  <= mret;
          pc_q    <= pc;
          addr_q  <= fault_addr;
          instr_q <= instr;
          if (control_op != OP_NORMAL) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= mtvec;
          end else if (mret) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= mepc;
          end
        end
        COMMIT: begin
          state <= DONE;
        end
        DONE: begin
          if (!control_stage) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Trap cause/value from the latched visit. Fault code 011 is folded into
  // illegal instruction (010), which also selects the instruction word as mtval.
  always_comb begin
    fault_code = (fault_q == 3'b011) ? 3'b010 : fault_q;
    case (op_q)
      OP_EXT:  trap_cause = CAUSE_EXT;
      OP_SW:   trap_cause = CAUSE_SW;
      default: trap_cause = {{(XLEN-3){1'b0}}, fault_code};
    endcase
    if (op_q != OP_TRAP) begin
      trap_val = '0;
    end else if (fault_code == 3'b010) begin
      trap_val = instr_q;
    end else begin
      trap_val = addr_q;
    end
  end

  assign commit_trap = (state == COMMIT) && (op_q != OP_NORMAL);
  assign commit_mret = (state == COMMIT) && (op_q == OP_NORMAL) && mret_q;

  // CSR storage. Software writes are applied first and the commit updates
  // afterwards, so the commit overrides a same-cycle write only for the
  // registers it actually touches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_meie     <= 1'b0;
      mie_msie     <= 1'b0;
      mtvec        <= MTVEC_RESET & ALIGN_MASK;
      mepc         <= '0;
      mcause       <= '0;
      mtval        <= '0;
    end else begin
      if (csr_wr_en) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mstatus_mie  <= csr_wdata[3];
            mstatus_mpie <= csr_wdata[7];
          end
          CSR_MIE: begin
            mie_msie <= csr_wdata[3];
            mie_meie <= csr_wdata[11];
          end
          CSR_MTVEC:  mtvec  <= csr_wdata & ALIGN_MASK;
          CSR_MEPC:   mepc   <= csr_wdata & ALIGN_MASK;
          CSR_MCAUSE: mcause <= csr_wdata;
          CSR_MTVAL:  mtval  <= csr_wdata;
          default: begin
          end
        endcase
      end
      if (commit_trap) begin
        mepc         <= pc_q & ALIGN_MASK;
        mcause       <= trap_cause;
        mtval        <= trap_val;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (commit_mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end
    end
  end

  // CSR read mux; only the implemented mstatus/mie bits read back as set.
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[3] = mstatus_mie;
        csr_rdata[7] = mstatus_mpie;
      end
      CSR_MIE: begin
        csr_rdata[3]  = mie_msie;
        csr_rdata[11] = mie_meie;
      end
      CSR_MTVEC:  csr_rdata = mtvec;
      CSR_MEPC:   csr_rdata = mepc;
      CSR_MCAUSE: csr_rdata = mcause;
      CSR_MTVAL:  csr_rdata = mtval;
      default:    csr_rdata = '0;
    endcase
  end

  assign ext_int_en = mstatus_mie & mie_meie;
  assign sw_int_en  = mstatus_mie & mie_msie;

endmodule

// File: tb/tb_trap_unit.sv
// ---------------------------------------------------------------------------
// tb_trap_unit
//   Table-driven bench for trap_unit. Each table row is one CONTROL-stage
//   visit with hand-computed expected redirect and CSR state afterwards;
//   hand-written sequences cover interrupt-enable timing, no-op visits, CSR
//   write masking and asynchronous reset in the middle of a visit.
// ---------------------------------------------------------------------------
module tb_trap_unit;

  logic        clk;
  logic        reset_n;
  logic        control_stage;
  logic [1:0]  control_op;
  logic [2:0]  fault_num;
  logic        mret;
  logic [31:0] pc;
  logic [31:0] fault_addr;
  logic [31:0] instr;
  logic [11:0] csr_addr;
  logic        csr_wr_en;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ext_int_en;
  logic        sw_int_en;

  int tests_run;
  int tests_failed;

  trap_unit #(
    .XLEN        (32),
    .MTVEC_RESET (32'h0000_0102)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .control_stage  (control_stage),
    .control_op     (control_op),
    .fault_num      (fault_num),
    .mret           (mret),
    .pc             (pc),
    .fault_addr     (fault_addr),
    .instr          (instr),
    .csr_addr       (csr_addr),
    .csr_wr_en      (csr_wr_en),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ext_int_en     (ext_int_en),
    .sw_int_en      (sw_int_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  fnum;
    logic        mret;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] instr;
    int          hold;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        exp_pulse;
    logic [31:0] exp_rpc;
    logic [31:0] exp_mcause;
    logic [31:0] exp_mepc;
    logic [31:0] exp_mtval;
    logic [31:0] exp_mstatus;
    logic        exp_ext;
  } vec_t;

  vec_t vecs[17];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic csrWrite(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk);
    csr_addr  = addr;
    csr_wdata = data;
    csr_wr_en = 1'b1;
    @(negedge clk);
    csr_wr_en = 1'b0;
  endtask

  task automatic csrRead(input logic [11:0] addr, output logic [31:0] data);
    csr_addr = addr;
    #1;
    data = csr_rdata;
  endtask

  // One CONTROL-stage visit. k counts rising edges since control_stage was
  // raised; the redirect pulse is expected at k==2 (the COMMIT cycle). An
  // optional CSR write is driven during that COMMIT cycle.
  task automatic applyStimulus(input vec_t v, output int pulses, output int first_k,
                               output logic [31:0] rpc_seen, output logic ext_k2,
                               output logic ext_k3);
    pulses   = 0;
    first_k  = 0;
    rpc_seen = '0;
    ext_k2   = 1'b0;
    ext_k3   = 1'b0;
    @(negedge clk);
    control_op    = v.op;
    fault_num     = v.fnum;
    mret          = v.mret;
    pc            = v.pc;
    fault_addr    = v.addr;
    instr         = v.instr;
    control_stage = 1'b1;
    for (int k = 1; k <= v.hold + 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (redirect_valid) begin
        pulses++;
        if (first_k == 0) begin
          first_k  = k;
          rpc_seen = redirect_pc;
        end
      end
      if (k == 2) ext_k2 = ext_int_en;
      if (k == 3) ext_k3 = ext_int_en;
      if (csr_wr_en) csr_wr_en = 1'b0;
      if (v.wr_en && k == 2) begin
        csr_addr  = v.wr_addr;
        csr_wdata = v.wr_data;
        csr_wr_en = 1'b1;
      end
      if (k == v.hold) control_stage = 1'b0;
    end
  endtask

  initial begin
    int          pulses;
    int          first_k;
    int          total_pulses;
    logic [31:0] rpc_seen;
    logic [31:0] rd;
    logic        ext_k2;
    logic        ext_k3;
    vec_t        v;

    tests_run     = 0;
    tests_failed  = 0;
    reset_n       = 1'b0;
    control_stage = 1'b0;
    control_op    = 2'b11;
    fault_num     = 3'b000;
    mret          = 1'b0;
    pc            = '0;
    fault_addr    = '0;
    instr         = '0;
    csr_addr      = 12'h000;
    csr_wr_en     = 1'b0;
    csr_wdata     = '0;

    //           op     fnum    mret  pc            addr          instr         hold wr    wr_addr  wr_data       pulse rpc           mcause        mepc          mtval         mstatus       ext
    vecs[0]  = '{2'b00, 3'b010, 1'b0, 32'h0000_0104, 32'h1234_5678, 32'hFFFF_FFFF, 2, 1'b0, 12'h000, 32'h0,        1'b1, 32'h0000_0200, 32'h0000_0002, 32'h0000_0104, 32'hFFFF_FFFF, 32'h80, 1'b0};
    vecs[1]  = '{2'b11, 3'b000, 1'b1, 32'h0000_0500, 32'h0,         32'h0,         2, 1'b0, 12'h000, 32'h0,        1'b1, 32'h0000_0104, 32'h0000_0002, 32'h0000_0104, 32'hFFFF_FFFF, 32'h88, 1'b1};
    vecs[2]  = '{2'b00, 3'b111, 1'b0, 32'h0000_2002, 32'h8000_0003, 32'h0000_0013, 4, 1'b0, 12'h000, 32'h0,        1'b1, 32'h0000_0200, 32'h0000_0007, 32'h0000_2000, 32'h8000_0003, 32'h80, 1'b0};
    vecs[3]  = '{2'b00, 3'b011, 1'b1, 32'h0000_3000, 32'h0000_0044, 32'hDEAD_BEEF, 2, 1'b0, 12'h000, 32'h0,        1'b1, 32'h0000_0200, 32'h0000_0002, 32'h0000_3000, 32'hDEAD_BEEF, 32'h00, 1'b0};
    vecs[4]  = '{2'b11, 3'b000, 1'b1, 32'h0000_9999, 32'h0,         32'h0,         2, 1'b0, 12'h000, 32'h0,        1'b1, 32'h0000_3000, 32'h0000_0002, 32'h0000_3000, 32'hDEAD_BEEF, 32'h80, 1'b0};
    vecs[5]  = '{2'b11, 3'b000, 1'b1, 32'h0000_9999, 32'h0,         32'h0,         2, 1'b0, 12'h000, 32'h0,        1'b1, 32'h0000_3000, 32'h0000_0002, 32'h0000_3000, 32'hDEAD_BEEF, 32'h88, 1'b1};
    vecs[6]  = '{2'b01, 3'b000, 1'b0, 32'h0000_4000, 32'h0000_0055, 32'h0000_0066, 2, 1'b0, 12'h000, 32'h0,        1'b1, 32'h0000_0200, 32'h8000_000B, 32'h0000_4000, 32'h0000_0000, 32'h80, 1'b0};
    vecs[7]  = '{2'b11, 3'b000, 1'b1, 32'h0,         32'h0,         32'h0,         2, 1'b0, 12'h000, 32'h0,        1'b1, 32'h0000_4000, 32'h8000_000B, 32'h0000_4000, 32'h0000_0000, 32'h88, 1'b1};
    vecs[8]  = '{2'b10, 3'b101, 1'b0, 32'h0000_5001, 32'h0000_0077, 32'h0,         2, 1'b0, 12'h000, 32'h0,        1'b1, 32'h0000_0200, 32'h8000_0003, 32'h0000_5000, 32'h0000_0000, 32'h80, 1'b0};
    vecs[9]  = '{2'b11, 3'b000, 1'b1, 32'h0,         32'h0,         32'h0,         2, 1'b0, 12'h000, 32'h0,        1'b1, 32'h0000_5000, 32'h8000_0003, 32'h0000_5000, 32'h0000_0000, 32'h88, 1'b1};
    vecs[10] = '{2'b00, 3'b000, 1'b0, 32'h0000_6000, 32'h1111_0000, 32'h0,         2, 1'b0, 12'h000, 32'h0,        1'b1, 32'h0000_0200, 32'h0000_0000, 32'h0000_6000, 32'h1111_0000, 32'h80, 1'b0};
    vecs[11] = '{2'b00, 3'b001, 1'b0, 32'h0000_7004, 32'h0000_2222, 32'h0,         2, 1'b0, 12'h000, 32'h0,        1'b1, 32'h0000_0200, 32'h0000_0001, 32'h0000_7004, 32'h0000_2222, 32'h00, 1'b0};
    vecs[12] = '{2'b11, 3'b000, 1'b1, 32'h0,         32'h0,         32'h0,         2, 1'b0, 12'h000, 32'h0,        1'b1, 32'h0000_7004, 32'h0000_0001, 32'h0000_7004, 32'h0000_2222, 32'h80, 1'b0};
    vecs[13] = '{2'b11, 3'b000, 1'b1, 32'h0,         32'h0,         32'h0,         2, 1'b0, 12'h000, 32'h0,        1'b1, 32'h0000_7004, 32'h0000_0001, 32'h0000_7004, 32'h0000_2222, 32'h88, 1'b1};
    vecs[14] = '{2'b00, 3'b100, 1'b0, 32'h0000_8000, 32'h0000_3333, 32'h0,         2, 1'b1, 12'h300, 32'h0,        1'b1, 32'h0000_0200, 32'h0000_0004, 32'h0000_8000, 32'h0000_3333, 32'h80, 1'b0};
    vecs[15] = '{2'b11, 3'b000, 1'b1, 32'h0,         32'h0,         32'h0,         2, 1'b1, 12'h341, 32'h0000_9003, 1'b1, 32'h0000_8000, 32'h0000_0004, 32'h0000_9000, 32'h0000_3333, 32'h88, 1'b1};
    vecs[16] = '{2'b00, 3'b110, 1'b0, 32'h0000_A000, 32'h0000_4444, 32'h0,         2, 1'b1, 12'h341, 32'h0000_BBBC, 1'b1, 32'h0000_0200, 32'h0000_0006, 32'h0000_A000, 32'h0000_4444, 32'h80, 1'b0};

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("reset redirect_valid", 32'(redirect_valid), 32'h0);
    checkOutput("reset redirect_pc", redirect_pc, 32'h0);
    csrRead(12'h305, rd); checkOutput("reset mtvec", rd, 32'h0000_0100);
    csrRead(12'h300, rd); checkOutput("reset mstatus", rd, 32'h0);
    csrRead(12'h342, rd); checkOutput("reset mcause", rd, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Setup: vector base, interrupts globally and individually enabled
    csrWrite(12'h305, 32'h0000_0200);
    csrWrite(12'h300, 32'hFFFF_FFFF);
    csrWrite(12'h304, 32'hFFFF_FFFF);
    csrRead(12'h300, rd); checkOutput("mstatus write mask", rd, 32'h0000_0088);
    csrRead(12'h304, rd); checkOutput("mie write mask", rd, 32'h0000_0808);
    checkOutput("ext_int_en setup", 32'(ext_int_en), 32'h1);

    // Table-driven visits
    for (int i = 0; i < 17; i++) begin
      v = vecs[i];
      applyStimulus(v, pulses, first_k, rpc_seen, ext_k2, ext_k3);
      checkOutput($sformatf("v%0d pulses", i), 32'(pulses), 32'(v.exp_pulse));
      if (v.exp_pulse) begin
        checkOutput($sformatf("v%0d latency", i), 32'(first_k), 32'd2);
        checkOutput($sformatf("v%0d redirect_pc", i), rpc_seen, v.exp_rpc);
      end
      csrRead(12'h342, rd); checkOutput($sformatf("v%0d mcause", i), rd, v.exp_mcause);
      csrRead(12'h341, rd); checkOutput($sformatf("v%0d mepc", i), rd, v.exp_mepc);
      csrRead(12'h343, rd); checkOutput($sformatf("v%0d mtval", i), rd, v.exp_mtval);
      csrRead(12'h300, rd); checkOutput($sformatf("v%0d mstatus", i), rd, v.exp_mstatus);
      checkOutput($sformatf("v%0d ext_int_en", i), 32'(ext_int_en), 32'(v.exp_ext));
      checkOutput($sformatf("v%0d sw_int_en", i), 32'(sw_int_en), 32'(v.exp_ext));
    end

    // ext_int_en stays high through COMMIT and drops the cycle after
    csrWrite(12'h300, 32'h0000_0008);
    checkOutput("ext_int_en re-enabled", 32'(ext_int_en), 32'h1);
    v = '{2'b01, 3'b000, 1'b0, 32'h0000_C000, 32'h0, 32'h0, 2, 1'b0, 12'h000, 32'h0,
          1'b1, 32'h0000_0200, 32'h8000_000B, 32'h0000_C000, 32'h0, 32'h80, 1'b0};
    applyStimulus(v, pulses, first_k, rpc_seen, ext_k2, ext_k3);
    checkOutput("ext int pulses", 32'(pulses), 32'd1);
    checkOutput("ext int redirect_pc", rpc_seen, 32'h0000_0200);
    checkOutput("ext_int_en at N+2", 32'(ext_k2), 32'h1);
    checkOutput("ext_int_en at N+3", 32'(ext_k3), 32'h0);
    csrRead(12'h342, rd); checkOutput("ext int mcause", rd, 32'h8000_000B);

    // Ten normal visits without mret: nothing may change
    total_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      v = '{2'b11, 3'(i), 1'b0, 32'h100 * i + 32'h0000_F000, 32'h0000_0ABC, 32'h0000_0DEF, 2 + (i % 3),
            1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
      applyStimulus(v, pulses, first_k, rpc_seen, ext_k2, ext_k3);
      total_pulses += pulses;
    end
    checkOutput("normal visits pulses", 32'(total_pulses), 32'd0);
    checkOutput("normal visits redirect_pc held", redirect_pc, 32'h0000_0200);
    csrRead(12'h300, rd); checkOutput("normal visits mstatus", rd, 32'h0000_0080);
    csrRead(12'h342, rd); checkOutput("normal visits mcause", rd, 32'h8000_000B);
    csrRead(12'h341, rd); checkOutput("normal visits mepc", rd, 32'h0000_C000);
    csrRead(12'h343, rd); checkOutput("normal visits mtval", rd, 32'h0);
    csrRead(12'h305, rd); checkOutput("normal visits mtvec", rd, 32'h0000_0200);
    csrRead(12'h304, rd); checkOutput("normal visits mie", rd, 32'h0000_0808);

    // CSR write masking and unmapped reads
    csrWrite(12'h304, 32'hFFFF_F7F7);
    csrRead(12'h304, rd); checkOutput("mie clear mask", rd, 32'h0);
    csrWrite(12'h304, 32'h0000_0008);
    csrWrite(12'h300, 32'h0000_0008);
    checkOutput("sw_int_en only", 32'(sw_int_en), 32'h1);
    checkOutput("ext_int_en off", 32'(ext_int_en), 32'h0);
    csrWrite(12'h305, 32'h0000_1237);
    csrRead(12'h305, rd); checkOutput("mtvec align", rd, 32'h0000_1234);
    csrWrite(12'h341, 32'h0000_5557);
    csrRead(12'h341, rd); checkOutput("mepc align", rd, 32'h0000_5554);
    csrRead(12'h123, rd); checkOutput("unmapped read", rd, 32'h0);

    // Asynchronous reset during CAPTURE
    @(negedge clk);
    control_op    = 2'b00;
    fault_num     = 3'b010;
    pc            = 32'h0000_D000;
    control_stage = 1'b1;
    csr_addr      = 12'h342;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mid reset redirect_valid", 32'(redirect_valid), 32'h0);
    checkOutput("mid reset mcause", csr_rdata, 32'h0);
    csrRead(12'h305, rd); checkOutput("mid reset mtvec", rd, 32'h0000_0100);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    total_pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (redirect_valid) total_pulses++;
    end
    checkOutput("post reset pulses", 32'(total_pulses), 32'd0);
    control_stage = 1'b0;
    repeat (2) @(negedge clk);

    // Fresh visit after reset uses the reset vector
    v = '{2'b00, 3'b101, 1'b0, 32'h0000_E000, 32'h0000_00AB, 32'h0, 2, 1'b0, 12'h000, 32'h0,
          1'b1, 32'h0000_0100, 32'h0000_0005, 32'h0000_E000, 32'h0000_00AB, 32'h00, 1'b0};
    applyStimulus(v, pulses, first_k, rpc_seen, ext_k2, ext_k3);
    checkOutput("after reset pulses", 32'(pulses), 32'd1);
    checkOutput("after reset redirect_pc", rpc_seen, 32'h0000_0100);
    csrRead(12'h342, rd); checkOutput("after reset mcause", rd, 32'h0000_0005);
    csrRead(12'h343, rd); checkOutput("after reset mtval", rd, 32'h0000_00AB);
    csrRead(12'h300, rd); checkOutput("after reset mstatus", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
